// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// data width and wait-counter sizing.
package data_mem_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 4;
  localparam int WAIT_MIN   = 1;
  localparam int WAIT_MAX   = 15;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_t;

  // True when a requested wait-state count fits the counter and is non-zero
  function automatic bit wait_cycles_legal(input int cycles);
    return (cycles >= WAIT_MIN) && (cycles <= WAIT_MAX);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_ram.sv
// dmem_ram: single-port synchronous 32-bit RAM with a read-enabled,
// resettable read register. Build option DMEM_DEBUG_EN adds a second,
// free-running read-only port for debug inspection.
module dmem_ram
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
`ifdef DMEM_DEBUG_EN
  ,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data
`endif
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  // Storage array: contents are deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register only updates on a completed read, so it holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

`ifdef DMEM_DEBUG_EN
  // Debug port samples every cycle; a same-cycle write returns the old word
  always_ff @(posedge clk) begin
    debug_data <= mem[debug_addr];
  end
`endif

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: memory end of the CPU load/store interface. A request is
// captured in IDLE, held for WAIT_CYCLES stall cycles, committed to the RAM
// on the last WAIT edge and acknowledged by a stall-free DONE cycle.
// Build option DMEM_DEBUG_EN adds the debug_addr/debug_data read port.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_dout,
  output logic [31:0]           mem_din,
  output logic                  mem_stall
`ifdef DMEM_DEBUG_EN
  ,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [31:0]           debug_data
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(WAIT_CYCLES - 1);

  generate
    if (!wait_cycles_legal(WAIT_CYCLES)) begin : g_bad_wait_cycles
      $error("data_mem_ctrl: WAIT_CYCLES must lie within 1..15");
    end
  endgenerate

  dmem_state_t           state;
  logic [CNT_WIDTH-1:0]  wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  write_q;
  logic                  request;
  logic                  commit;
  logic                  unused_addr_bits;

  assign request = mem_ren | mem_wen;

  // Byte-lane and high address bits are dropped, so addresses alias modulo depth
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

  // Final WAIT cycle: the captured access takes effect on this edge unless reset wins
  assign commit = (state == DMEM_WAIT) && (wait_cnt == '0) && !rst;

  // Stall covers the accepting IDLE cycle and all WAIT cycles, never DONE
  assign mem_stall = ((state == DMEM_IDLE) && request) || (state == DMEM_WAIT);

  // Access sequencer: capture in IDLE, count down in WAIT, one DONE cycle, back to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DMEM_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (request) begin
            addr_q   <= mem_addr[ADDR_WIDTH+1:2];
            wdata_q  <= mem_dout;
            write_q  <= mem_wen;
            wait_cnt <= CNT_LOAD;
            state    <= DMEM_WAIT;
          end
        end
        DMEM_WAIT: begin
          if (wait_cnt == '0) begin
            state <= DMEM_DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DMEM_DONE: begin
          state <= DMEM_IDLE;
        end
        default: begin
          state <= DMEM_IDLE;
        end
      endcase
    end
  end

  dmem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .we         (commit & write_q),
    .re         (commit & ~write_q),
    .addr       (addr_q),
    .wdata      (wdata_q),
    .rdata      (mem_din)
`ifdef DMEM_DEBUG_EN
    ,
    .debug_addr (debug_addr),
    .debug_data (debug_data)
`endif
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl with WAIT_CYCLES=2, ADDR_WIDTH=10.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_data_mem_ctrl;

  localparam int ADDR_WIDTH  = 10;
  localparam int WAIT_CYCLES = 2;

  logic        clk;
  logic        rst;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
`ifdef DMEM_DEBUG_EN
  logic [ADDR_WIDTH-1:0] debug_addr;
  logic [31:0]           debug_data;
`endif

  int compared   = 0;
  int mismatched = 0;

  data_mem_ctrl #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .mem_stall  (mem_stall)
`ifdef DMEM_DEBUG_EN
    ,
    .debug_addr (debug_addr),
    .debug_data (debug_data)
`endif
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point with failure accounting
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One complete access: stall must be high for WAIT_CYCLES+1 cycles, low in DONE.
  // When scramble is set, address and data are changed while the access waits.
  // Returns at the DONE-cycle falling edge with the request still driven if hold is set.
  task automatic applyStimulus(input string tag, input logic ren, input logic wen,
                               input logic [31:0] addr, input logic [31:0] dout,
                               input logic hold, input logic scramble);
    @(negedge clk);
    mem_ren  = ren;
    mem_wen  = wen;
    mem_addr = addr;
    mem_dout = dout;
    #1;
    checkOutput({tag, "_stall_accept"}, {31'd0, mem_stall}, 32'd1);
    for (int i = 0; i < WAIT_CYCLES; i++) begin
      @(negedge clk);
      if (scramble) begin
        mem_addr = addr + 32'h4;
        mem_dout = 32'hFFFF_FFFF;
        mem_ren  = ~ren;
      end
      #1;
      checkOutput({tag, "_stall_wait"}, {31'd0, mem_stall}, 32'd1);
    end
    @(negedge clk);
    #1;
    checkOutput({tag, "_stall_done"}, {31'd0, mem_stall}, 32'd0);
    if (!hold) begin
      mem_ren = 1'b0;
      mem_wen = 1'b0;
    end
  endtask

  initial begin
    rst      = 1'b1;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_dout = '0;
`ifdef DMEM_DEBUG_EN
    debug_addr = '0;
`endif
    $display("[TB] starting data_mem_ctrl directed test");

    repeat (2) @(negedge clk);
    checkOutput("reset_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("reset_din", mem_din, 32'd0);
    rst = 1'b0;

    // Write then read back; a write leaves mem_din at its reset value
    applyStimulus("wr_deadbeef", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checkOutput("wr_keeps_din", mem_din, 32'd0);
    applyStimulus("rd_0x10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    checkOutput("rd_deadbeef", mem_din, 32'hDEAD_BEEF);

    // Byte-lane bits ignored, high address bits alias
    applyStimulus("wr_12345678", 1'b0, 1'b1, 32'h10, 32'h1234_5678, 1'b0, 1'b0);
    applyStimulus("rd_0x13", 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0);
    checkOutput("rd_low_bits", mem_din, 32'h1234_5678);
    applyStimulus("wr_0x20_clear", 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 1'b0);
    applyStimulus("rd_0x20_clear", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
    checkOutput("rd_clear", mem_din, 32'h0);
    applyStimulus("rd_alias", 1'b1, 1'b0, 32'h10 + 32'h1000, 32'h0, 1'b0, 1'b0);
    checkOutput("rd_alias_val", mem_din, 32'h1234_5678);

    // Simultaneous ren and wen behaves as a write
    applyStimulus("rw_both", 1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, 1'b0, 1'b0);
    checkOutput("rw_keeps_din", mem_din, 32'h1234_5678);
    applyStimulus("rd_0x20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
    checkOutput("rd_a5a5", mem_din, 32'hA5A5_A5A5);

    // Inputs changed during WAIT must not affect the captured access
    applyStimulus("wr_0x44", 1'b0, 1'b1, 32'h44, 32'h4444_4444, 1'b0, 1'b0);
    applyStimulus("wr_scramble", 1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, 1'b0, 1'b1);
    applyStimulus("rd_0x40", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
    checkOutput("rd_captured", mem_din, 32'h0BAD_F00D);
    applyStimulus("rd_0x44", 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0);
    checkOutput("rd_untouched", mem_din, 32'h4444_4444);

    // Back-to-back reads with the request held through DONE
    applyStimulus("wr_0x0", 1'b0, 1'b1, 32'h0, 32'h1111_1111, 1'b0, 1'b0);
    applyStimulus("wr_0x4", 1'b0, 1'b1, 32'h4, 32'h2222_2222, 1'b0, 1'b0);
    applyStimulus("b2b_rd0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("b2b_din0", mem_din, 32'h1111_1111);
    applyStimulus("b2b_rd4", 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0);
    checkOutput("b2b_din4", mem_din, 32'h2222_2222);
    mem_ren = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("b2b_idle_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("b2b_din_hold", mem_din, 32'h2222_2222);

    // Reset on the commit cycle discards the pending write and clears mem_din
    applyStimulus("wr_0x30_old", 1'b0, 1'b1, 32'h30, 32'h7777_7777, 1'b0, 1'b0);
    applyStimulus("rd_0x30_old", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0);
    checkOutput("rd_0x30_pre", mem_din, 32'h7777_7777);
    @(negedge clk);
    mem_wen  = 1'b1;
    mem_addr = 32'h30;
    mem_dout = 32'h1;
    @(negedge clk);
    mem_wen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("rst_mid_din", mem_din, 32'd0);
    applyStimulus("rd_0x30_post", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0);
    checkOutput("rst_write_dropped", mem_din, 32'h7777_7777);

`ifdef DMEM_DEBUG_EN
    // Debug port returns the word one cycle later without disturbing the FSM
    applyStimulus("wr_cafef00d", 1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b0, 1'b0);
    @(negedge clk);
    debug_addr = 10'd4;
    @(negedge clk);
    #1;
    checkOutput("dbg_data", debug_data, 32'hCAFE_F00D);
    checkOutput("dbg_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("dbg_din", mem_din, 32'h7777_7777);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
